// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: load-use bubbles,
// taken-branch squashes and memory-wait stalls with a timeout fault.
module hazard_stall_ctrl #(
   parameter int unsigned bus     = 32,
   parameter int unsigned MAXWAIT = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [3:0]     RSAdec,
   input  logic [3:0]     RSBdec,
   input  logic           useRSAdec,
   input  logic           useRSBdec,
   input  logic [3:0]     RDexe,
   input  logic           selMEMRDexe,
   input  logic           selBRANCHexe,
   input  logic           branchTaken,
   input  logic           memReq,
   input  logic           memAck,
   output logic           enPC,
   output logic           enIFID,
   output logic           enIDEX,
   output logic           enEXMEM,
   output logic           flushIFID,
   output logic           flushIDEX,
   output logic [1:0]     state,
   output logic           memFault,
   output logic [bus-1:0] stallCycles,
   output logic [bus-1:0] flushCount
);

   localparam int unsigned WaitW = $clog2(MAXWAIT + 1);
   localparam logic [WaitW-1:0] WaitLast = WaitW'(MAXWAIT - 1);

   typedef enum logic [1:0] {
      StRun     = 2'b00,
      StBubble  = 2'b01,
      StMemWait = 2'b10,
      StFault   = 2'b11
   } state_e;

   state_e           state_q, state_d;
   logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
   logic             mem_fault_q, mem_fault_d;
   logic [bus-1:0]   stall_cycles_q, stall_cycles_d;
   logic [bus-1:0]   flush_count_q, flush_count_d;

   logic mem_stall;
   logic br_flush;
   logic load_use;
   logic hit_a;
   logic hit_b;

   assign mem_stall = memReq & ~memAck;
   assign br_flush  = selBRANCHexe & branchTaken;
   assign hit_a     = useRSAdec & (RSAdec == RDexe);
   assign hit_b     = useRSBdec & (RSBdec == RDexe);
   assign load_use  = selMEMRDexe & (hit_a | hit_b);

   always_comb begin
      enPC           = 1'b1;
      enIFID         = 1'b1;
      enIDEX         = 1'b1;
      enEXMEM        = 1'b1;
      flushIFID      = 1'b0;
      flushIDEX      = 1'b0;
      state_d        = StRun;
      wait_cnt_d     = '0;
      mem_fault_d    = mem_fault_q;
      flush_count_d  = flush_count_q;
      stall_cycles_d = stall_cycles_q;

      if (state_q == StFault) begin
         enPC       = 1'b0;
         enIFID     = 1'b0;
         enIDEX     = 1'b0;
         enEXMEM    = 1'b0;
         state_d    = StFault;
         wait_cnt_d = wait_cnt_q;
      end else if (mem_stall) begin
         // Whole pipe frozen; a pending branch or load-use is re-evaluated on release.
         enPC       = 1'b0;
         enIFID     = 1'b0;
         enIDEX     = 1'b0;
         enEXMEM    = 1'b0;
         wait_cnt_d = wait_cnt_q + 1'b1;
         if (wait_cnt_q == WaitLast) begin
            state_d     = StFault;
            mem_fault_d = 1'b1;
         end else begin
            state_d = StMemWait;
         end
      end else if (br_flush) begin
         flushIFID = 1'b1;
         flushIDEX = 1'b1;
         state_d   = StRun;
         if (~&flush_count_q) begin
            flush_count_d = flush_count_q + 1'b1;
         end
      end else if (load_use && (state_q != StBubble)) begin
         enPC      = 1'b0;
         enIFID    = 1'b0;
         flushIDEX = 1'b1;
         state_d   = StBubble;
      end

      if (!enPC && (state_q != StFault) && (~&stall_cycles_q)) begin
         stall_cycles_d = stall_cycles_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StRun;
         wait_cnt_q     <= '0;
         mem_fault_q    <= 1'b0;
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         mem_fault_q    <= mem_fault_d;
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign state       = state_q;
   assign memFault    = mem_fault_q;
   assign stallCycles = stall_cycles_q;
   assign flushCount  = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with 4-bit counters and MAXWAIT=4.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] RSAdec, RSBdec, RDexe;
  logic       useRSAdec, useRSBdec, selMEMRDexe, selBRANCHexe, branchTaken;
  logic       memReq, memAck;
  logic       enPC, enIFID, enIDEX, enEXMEM, flushIFID, flushIDEX;
  logic [1:0] state;
  logic       memFault;
  logic [3:0] stallCycles, flushCount;
  logic [5:0] ctl;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // {enPC, enIFID, enIDEX, enEXMEM, flushIFID, flushIDEX}
  assign ctl = {enPC, enIFID, enIDEX, enEXMEM, flushIFID, flushIDEX};

  hazard_stall_ctrl #(.bus(4), .MAXWAIT(4)) dut (
    .clk(clk), .rst(rst),
    .RSAdec(RSAdec), .RSBdec(RSBdec), .useRSAdec(useRSAdec), .useRSBdec(useRSBdec),
    .RDexe(RDexe), .selMEMRDexe(selMEMRDexe), .selBRANCHexe(selBRANCHexe),
    .branchTaken(branchTaken), .memReq(memReq), .memAck(memAck),
    .enPC(enPC), .enIFID(enIFID), .enIDEX(enIDEX), .enEXMEM(enEXMEM),
    .flushIFID(flushIFID), .flushIDEX(flushIDEX), .state(state),
    .memFault(memFault), .stallCycles(stallCycles), .flushCount(flushCount)
  );

  task automatic chk(input string tag, input logic ok);
    ncmp++;
    if (ok !== 1'b1) begin
      nerr++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic clear_inputs();
    RSAdec = 4'd0; RSBdec = 4'd0; RDexe = 4'd0;
    useRSAdec = 1'b0; useRSBdec = 1'b0; selMEMRDexe = 1'b0;
    selBRANCHexe = 1'b0; branchTaken = 1'b0; memReq = 1'b0; memAck = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    step();
    reset_dut();
    chk("rst_state", state === 2'b00);
    chk("rst_fault", memFault === 1'b0);
    chk("rst_stall", stallCycles === 4'd0);
    chk("rst_flush", flushCount === 4'd0);
    chk("rst_ctl", ctl === 6'b111100);

    // Load-use via RSA
    RDexe = 4'd5; selMEMRDexe = 1'b1; RSAdec = 4'd5; useRSAdec = 1'b1;
    #1 chk("lu_ctl", ctl === 6'b001101);
    step();
    chk("lu_state", state === 2'b01);
    chk("lu_bubble_ctl", ctl === 6'b111100);
    chk("lu_stall", stallCycles === 4'd1);
    clear_inputs();
    step();
    chk("lu_back_run", state === 2'b00);

    // Load-use via RSB, register 0, and non-load / unused source cases
    RDexe = 4'd9; selMEMRDexe = 1'b1; RSBdec = 4'd9; useRSBdec = 1'b1; RSAdec = 4'd9;
    #1 chk("lu_rsb_ctl", ctl === 6'b001101);
    step(); clear_inputs(); step();
    RDexe = 4'd0; selMEMRDexe = 1'b1; useRSAdec = 1'b1;
    #1 chk("lu_r0_ctl", ctl === 6'b001101);
    selMEMRDexe = 1'b0;
    #1 chk("no_load_ctl", ctl === 6'b111100);
    selMEMRDexe = 1'b1; useRSAdec = 1'b0; RSBdec = 4'd0;
    #1 chk("no_use_ctl", ctl === 6'b111100);
    RSAdec = 4'd8; useRSAdec = 1'b1;
    #1 chk("diff_reg_ctl", ctl === 6'b111100);

    // Taken branch with simultaneous load-use
    reset_dut();
    RDexe = 4'd3; selMEMRDexe = 1'b1; RSAdec = 4'd3; useRSAdec = 1'b1;
    selBRANCHexe = 1'b1; branchTaken = 1'b1;
    #1 chk("br_ctl", ctl === 6'b111111);
    step();
    chk("br_state", state === 2'b00);
    chk("br_flushcnt", flushCount === 4'd1);
    chk("br_stall", stallCycles === 4'd0);
    branchTaken = 1'b0; selMEMRDexe = 1'b0;
    #1 chk("br_not_taken_ctl", ctl === 6'b111100);

    // Memory wait of 3 cycles then ack
    reset_dut();
    memReq = 1'b1;
    #1 chk("mw_c1_ctl", ctl === 6'b000000);
    step();
    chk("mw_c2_state", state === 2'b10);
    chk("mw_c2_ctl", ctl === 6'b000000);
    step();
    chk("mw_c3_state", state === 2'b10);
    chk("mw_c3_ctl", ctl === 6'b000000);
    step();
    memAck = 1'b1;
    #1 chk("mw_ack_ctl", ctl === 6'b111100);
    step();
    chk("mw_state_after", state === 2'b00);
    chk("mw_stall", stallCycles === 4'd3);
    // memAck together with memReq, and memAck alone
    memReq = 1'b1; memAck = 1'b1;
    #1 chk("mw_zero_ctl", ctl === 6'b111100);
    memReq = 1'b0;
    #1 chk("ack_only_ctl", ctl === 6'b111100);
    step();
    chk("mw_zero_stall", stallCycles === 4'd3);

    // Branch held during a memory stall, flushed in the ack cycle
    reset_dut();
    memReq = 1'b1; selBRANCHexe = 1'b1; branchTaken = 1'b1;
    #1 chk("mbr_stall_ctl", ctl === 6'b000000);
    step();
    memAck = 1'b1;
    #1 chk("mbr_ack_ctl", ctl === 6'b111111);
    step();
    chk("mbr_flushcnt", flushCount === 4'd1);
    chk("mbr_stall", stallCycles === 4'd1);
    chk("mbr_state", state === 2'b00);

    // Timeout with MAXWAIT=4
    reset_dut();
    memReq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("to_stall_ctl", ctl === 6'b000000);
      chk("to_not_fault", memFault === 1'b0);
      step();
    end
    chk("to_state", state === 2'b11);
    chk("to_fault", memFault === 1'b1);
    chk("to_stall", stallCycles === 4'd4);
    memAck = 1'b1; memReq = 1'b0;
    step(); step(); step();
    chk("to_hold_state", state === 2'b11);
    chk("to_hold_ctl", ctl === 6'b000000);
    chk("to_hold_stall", stallCycles === 4'd4);
    chk("to_hold_fault", memFault === 1'b1);
    reset_dut();
    chk("to_rst_state", state === 2'b00);
    chk("to_rst_fault", memFault === 1'b0);

    // Reset in the middle of a memory wait
    memReq = 1'b1;
    step(); step();
    chk("rmw_state", state === 2'b10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1 chk("rmw_rst_state", state === 2'b00);
    chk("rmw_rst_stall", stallCycles === 4'd0);
    chk("rmw_rst_fault", memFault === 1'b0);
    chk("rmw_req_ctl", ctl === 6'b000000);
    memReq = 1'b0;
    #1 chk("rmw_idle_ctl", ctl === 6'b111100);

    // Saturation: alternating load-use / bubble pairs
    reset_dut();
    RDexe = 4'd7; selMEMRDexe = 1'b1; RSAdec = 4'd7; useRSAdec = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("sat_10", stallCycles === 4'd10);
    for (int i = 0; i < 20; i++) step();
    chk("sat_15", stallCycles === 4'd15);
    chk("sat_state", state === 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline sequencing controller for the 5-stage core. It drives the enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It resolves three conditions:
- load-use hazards between the Decode and Execute stages;
- taken-branch squashes resolved in Execute;
- multi-cycle data-memory/cache accesses, using a req/ack handshake with a timeout fault.

It also keeps saturating stall and flush statistics for debug.

## Interface
- bus, 32, width of statistics counters
- MAXWAIT, 16, max consecutive memory-stall cycles before fault (≥2)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- RSAdec  in  4  source register A of instruction in Decode
- RSBdec  in  4  source register B of instruction in Decode
- useRSAdec  in  1  Decode instruction reads RSA
- useRSBdec  in  1  Decode instruction reads RSB
- RDexe  in  4  destination register of instruction in Execute
- selMEMRDexe  in  1  Execute instruction is a load
- selBRANCHexe  in  1  Execute instruction is a branch
- branchTaken  in  1  branch in Execute resolved taken
- memReq  in  1  MEM stage holds an access (load, store or cache op)
- memAck  in  1  data memory/cache completes the access this cycle
- enPC, enIFID, enIDEX, enEXMEM  out  1 each  register load enables
- flushIFID, flushIDEX  out  1 each  load a bubble (all sel* = 0) instead of stage data
- state  out  2  RUN=00, BUBBLE=01, MEM_WAIT=10, FAULT=11
- memFault  out  1  sticky timeout flag
- stallCycles  out  bus  saturating count of cycles with enPC=0
- flushCount  out  bus  saturating count of taken-branch squashes

## Operation
- Controls are Mealy: a combinational function of the registered state and the current inputs. They must be stable before the negedge at which the pipeline registers capture.
- Condition terms:
  - memStall = memReq & ~memAck
  - brFlush = selBRANCHexe & branchTaken
  - loadUse = selMEMRDexe & ((useRSAdec & RSAdec==RDexe) | (useRSBdec & RSBdec==RDexe))
- Priority is FAULT > memStall > brFlush > loadUse > normal.
- FAULT: all enables 0, flushes 0. Left only by rst.
- memStall (state RUN, BUBBLE or MEM_WAIT): all four enables 0, flushes 0. Next state is MEM_WAIT, or FAULT on timeout.
- brFlush: all enables 1, flushIFID=1, flushIDEX=1. flushCount +1. Next state RUN.
- loadUse, only when state≠BUBBLE: enPC=0, enIFID=0, enIDEX=1, enEXMEM=1, flushIDEX=1. Next state BUBBLE.
- loadUse is ignored in BUBBLE. No double bubble is allowed.
- Normal: all enables 1, flushes 0. Next state RUN.
- MEM_WAIT with memAck=1: normal/brFlush/loadUse rules apply this cycle. Next state follows those rules.
- waitCnt (internal, clog2(MAXWAIT+1) bits):
  - increments on each posedge with memStall;
  - clears on each posedge without memStall;
  - when waitCnt+1==MAXWAIT on a memStall edge, next state is FAULT and memFault is set.
- stallCycles: +1 on every posedge where enPC=0, except in FAULT. Saturates at all-ones.
- flushCount: saturates at all-ones.
- Register numbers are compared on all 4 bits. Register 0 is not special.

## Timing
- Reset values (rst=1 at posedge): state=RUN, waitCnt=0, memFault=0, stallCycles=0, flushCount=0.
- Outputs after reset with idle inputs: enables=1, flushes=0.
- rst has priority over every event, including a pending timeout edge or MEM_WAIT.
- Load-use costs exactly 1 bubble cycle. The dependent instruction re-enters Decode the next cycle with the load in MEM.
- Taken branch costs 2 squashed slots (IF/ID and ID/EX), zero stall cycles.
- memAck in the same cycle as memReq means zero stall.
- N stalled cycles followed by ack: enables low for N cycles and high in the ack cycle.
- Branch taken during memStall: held, because EX is frozen. It is flushed in the ack cycle.
- Load-use during memStall: not counted separately. It is re-evaluated after release.
- memAck without memReq: ignored.

## Test plan
- Load-use: RDexe=5, selMEMRDexe=1, RSAdec=5, useRSAdec=1 → in that cycle enPC=enIFID=0 and flushIDEX=1; next cycle state=01, all enables 1; stallCycles=1.
- Taken branch with simultaneous load-use: selBRANCHexe=1, branchTaken=1, loadUse true → flushIFID=flushIDEX=1, enables 1, flushCount=1, stallCycles=0, next state RUN.
- Memory wait: memReq=1, memAck=0 for 3 cycles, then ack → enables 0 for 3 cycles, state=10 for 2 cycles, release in ack cycle; stallCycles=3.
- Timeout with MAXWAIT=4: memReq=1, memAck never → 4 stalled cycles, then state=11 and memFault=1. Enables stay 0 with stallCycles frozen at 4, until rst.
- Reset mid-MEM_WAIT: rst=1 after 2 stalled cycles → next cycle state=00, counters 0, memFault=0; enables 1 once memReq is deasserted.
- Saturation with bus=4: 20 consecutive load-use/normal pairs → stallCycles stops at 15.
